adc_trigger_capture: RTL and testbench

Acquisition-side consumer of the tx controller's ADC trigger line. Once armed by the HPS, it answers each trigger pulse with an acknowledge and captures a fixed-length record of ADC sample words into on-chip RAM. It repeats this for a programmed number of records, then raises a completion interrupt. It sits between the tx controller (trigger/ack pair) and the ocram sample buffer read by the HPS.

---
 rtl/adc_trigger_capture_pkg.sv | 20 ++
 rtl/adc_capture_addr_gen.sv | 59 +++++
 rtl/adc_trigger_capture.sv | 125 ++++++++++++
 tb/tb_adc_trigger_capture.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_trigger_capture_pkg.sv
// Shared types and constants for the ADC trigger/capture block.
// State encoding is visible on oState, so the numeric values are fixed.
package adc_trigger_capture_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_CAPTURE = 3'd2,
        S_DONE    = 3'd3,
        S_ERROR   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CFG  = 2'd1;
    localparam logic [1:0] ERR_OVF  = 2'd2;

    // Bit of the tx controller's control word that drives iTrigLine.
    localparam int unsigned TX_TRIG_BIT = 0;

endpackage

// File: rtl/adc_capture_addr_gen.sv
// Write pointer, per-record sample counter and registered ocram write port.
// End-of-record and overflow are flagged combinationally in the sampling cycle.
module adc_capture_addr_gen #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 15
) (
    input  logic              adcCLK,
    input  logic              iRst_n,
    input  logic              iClrPtr,
    input  logic              iClrCnt,
    input  logic              iCapture,
    input  logic              iFinalRec,
    input  logic [ADDR_W-1:0] iRecLength,
    input  logic [DATA_W-1:0] iAdcData,
    output logic              oWrEn,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [DATA_W-1:0] oWrData,
    output logic              oRecEnd,
    output logic              oOverflow
);

    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] sampleCnt;
    logic [ADDR_W-1:0] cntNext;

    // A write at the top address is only legal if it completes the final record.
    always_comb begin
        cntNext   = sampleCnt + ADDR_W'(1);
        oRecEnd   = iCapture && (cntNext == iRecLength);
        oOverflow = iCapture && (wrPtr == '1) && !(oRecEnd && iFinalRec);
    end

    always_ff @(posedge adcCLK) begin
        if (!iRst_n) begin
            wrPtr     <= '0;
            sampleCnt <= '0;
            oWrEn     <= 1'b0;
            oWrAddr   <= '0;
            oWrData   <= '0;
        end else begin
            oWrEn <= iCapture;
            if (iClrPtr) begin
                wrPtr <= '0;
            end else if (iCapture) begin
                wrPtr <= wrPtr + ADDR_W'(1);
            end
            if (iClrCnt) begin
                sampleCnt <= '0;
            end else if (iCapture) begin
                sampleCnt <= cntNext;
            end
            if (iCapture) begin
                oWrAddr <= wrPtr;
                oWrData <= iAdcData;
            end
        end
    end

endmodule

// File: rtl/adc_trigger_capture.sv
// Armed trigger-driven capture of fixed-length ADC records into ocram,
// with trigger acknowledge, completion interrupt and error reporting.
module adc_trigger_capture
    import adc_trigger_capture_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 15
) (
    input  logic              adcCLK,
    input  logic              iRst_n,
    input  logic              iTrigLine,
    output logic              oTrigAck,
    input  logic              iArm,
    input  logic              iAbort,
    input  logic [ADDR_W-1:0] iRecLength,
    input  logic [7:0]        iNumRecords,
    input  logic              iAdcValid,
    input  logic [DATA_W-1:0] iAdcData,
    output logic              oWrEn,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [DATA_W-1:0] oWrData,
    output logic              oIrq,
    output logic              oDone,
    output logic [7:0]        oRecCount,
    output logic              oTrigMissed,
    output logic [1:0]        oErr,
    output logic [2:0]        oState
);

    state_t            state;
    logic [ADDR_W-1:0] recLength;
    logic [7:0]        numRecords;
    logic              trigEdge;
    logic              armable;
    logic              badCfg;
    logic              capture;
    logic              finalRec;
    logic              recEnd;
    logic              overflow;

    // oTrigAck doubles as the registered trigger, so it also serves as the edge flag.
    always_comb begin
        trigEdge = iTrigLine && !oTrigAck;
        armable  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
        badCfg   = (iRecLength == '0) || (iNumRecords == 8'd0);
        capture  = (state == S_CAPTURE) && iAdcValid && !iAbort;
        finalRec = (oRecCount + 8'd1) == numRecords;
    end

    assign oState = state;

    adc_capture_addr_gen #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) addrGen (
        .adcCLK    (adcCLK),
        .iRst_n    (iRst_n),
        .iClrPtr   (!iAbort && iArm && armable),
        .iClrCnt   ((state == S_ARMED) && trigEdge),
        .iCapture  (capture),
        .iFinalRec (finalRec),
        .iRecLength(recLength),
        .iAdcData  (iAdcData),
        .oWrEn     (oWrEn),
        .oWrAddr   (oWrAddr),
        .oWrData   (oWrData),
        .oRecEnd   (recEnd),
        .oOverflow (overflow)
    );

    always_ff @(posedge adcCLK) begin
        if (!iRst_n) begin
            state       <= S_IDLE;
            recLength   <= '0;
            numRecords  <= '0;
            oTrigAck    <= 1'b0;
            oIrq        <= 1'b0;
            oDone       <= 1'b0;
            oRecCount   <= '0;
            oTrigMissed <= 1'b0;
            oErr        <= ERR_NONE;
        end else begin
            oTrigAck <= iTrigLine;
            oIrq     <= 1'b0;
            if (iAbort) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_ARMED: begin
                        if (trigEdge) state <= S_CAPTURE;
                    end
                    S_CAPTURE: begin
                        if (recEnd) oRecCount <= oRecCount + 8'd1;
                        if (overflow) begin
                            oErr  <= ERR_OVF;
                            state <= S_ERROR;
                        end else if (recEnd) begin
                            if (finalRec) begin
                                state <= S_DONE;
                                oIrq  <= 1'b1;
                                oDone <= 1'b1;
                            end else begin
                                state <= S_ARMED;
                            end
                        end
                    end
                    default: begin
                        if (iArm) begin
                            recLength   <= iRecLength;
                            numRecords  <= iNumRecords;
                            oRecCount   <= '0;
                            oTrigMissed <= 1'b0;
                            oDone       <= 1'b0;
                            oErr        <= badCfg ? ERR_CFG : ERR_NONE;
                            state       <= badCfg ? S_ERROR : S_ARMED;
                        end
                    end
                endcase
            end
            // Placed after the arm clear so a coincident stray trigger is still recorded.
            if (trigEdge && (state != S_ARMED)) oTrigMissed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Directed + randomized bench for adc_trigger_capture against a behavioural
// acquisition model (countdown per record, linear address, integer state).
module tb_adc_trigger_capture;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int ST_IDLE = 0, ST_ARMED = 1, ST_CAPTURE = 2, ST_DONE = 3, ST_ERROR = 4;

    logic              adcCLK;
    logic              iRst_n;
    logic              iTrigLine;
    logic              oTrigAck;
    logic              iArm;
    logic              iAbort;
    logic [ADDR_W-1:0] iRecLength;
    logic [7:0]        iNumRecords;
    logic              iAdcValid;
    logic [DATA_W-1:0] iAdcData;
    logic              oWrEn;
    logic [ADDR_W-1:0] oWrAddr;
    logic [DATA_W-1:0] oWrData;
    logic              oIrq;
    logic              oDone;
    logic [7:0]        oRecCount;
    logic              oTrigMissed;
    logic [1:0]        oErr;
    logic [2:0]        oState;

    adc_trigger_capture #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .adcCLK     (adcCLK),
        .iRst_n     (iRst_n),
        .iTrigLine  (iTrigLine),
        .oTrigAck   (oTrigAck),
        .iArm       (iArm),
        .iAbort     (iAbort),
        .iRecLength (iRecLength),
        .iNumRecords(iNumRecords),
        .iAdcValid  (iAdcValid),
        .iAdcData   (iAdcData),
        .oWrEn      (oWrEn),
        .oWrAddr    (oWrAddr),
        .oWrData    (oWrData),
        .oIrq       (oIrq),
        .oDone      (oDone),
        .oRecCount  (oRecCount),
        .oTrigMissed(oTrigMissed),
        .oErr       (oErr),
        .oState     (oState)
    );

    initial adcCLK = 1'b0;
    always #5 adcCLK = ~adcCLK;

    int checks = 0;
    int errors = 0;
    int irqSeen = 0;

    // Behavioural model state
    int mSt = ST_IDLE, mLen = 0, mRec = 0, recDone = 0, left = 0, nextAddr = 0;
    bit prevTrig = 0;
    bit eAck = 0, eWrEn = 0, eIrq = 0, eDone = 0, eMissed = 0;
    int eWrAddr = 0, eErr = 0;
    logic [DATA_W-1:0] eWrData = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelStep();
        bit rising;
        bit last;
        int old;
        rising = iTrigLine && !prevTrig;
        old    = mSt;
        eIrq   = 0;
        eWrEn  = 0;
        if (!iRst_n) begin
            mSt = ST_IDLE; mLen = 0; mRec = 0; recDone = 0; left = 0; nextAddr = 0;
            prevTrig = 0; eAck = 0; eDone = 0; eMissed = 0; eWrAddr = 0; eErr = 0; eWrData = '0;
            return;
        end
        eAck = iTrigLine;
        if (iAbort) begin
            mSt = ST_IDLE;
        end else if (mSt == ST_ARMED) begin
            if (rising) begin
                mSt  = ST_CAPTURE;
                left = mLen;
            end
        end else if (mSt == ST_CAPTURE) begin
            if (iAdcValid) begin
                eWrEn   = 1;
                eWrAddr = nextAddr;
                eWrData = iAdcData;
                nextAddr++;
                left--;
                last = (left == 0);
                if (last) recDone++;
                if (nextAddr == (1 << ADDR_W) && !(last && recDone == mRec)) begin
                    eErr = 2;
                    mSt  = ST_ERROR;
                end else if (last) begin
                    if (recDone == mRec) begin
                        mSt = ST_DONE; eIrq = 1; eDone = 1;
                    end else begin
                        mSt = ST_ARMED;
                    end
                end
            end
        end else if (iArm) begin
            mLen = int'(iRecLength); mRec = int'(iNumRecords);
            recDone = 0; eMissed = 0; eDone = 0; nextAddr = 0;
            if (mLen == 0 || mRec == 0) begin
                eErr = 1; mSt = ST_ERROR;
            end else begin
                eErr = 0; mSt = ST_ARMED;
            end
        end
        if (rising && old != ST_ARMED) eMissed = 1;
        prevTrig = iTrigLine;
    endtask

    task automatic checkAll();
        chk("state", 32'(oState), 32'(mSt));
        chk("ack", 32'(oTrigAck), 32'(eAck));
        chk("wrEn", 32'(oWrEn), 32'(eWrEn));
        chk("wrAddr", 32'(oWrAddr), 32'(eWrAddr));
        chk("wrData", oWrData, eWrData);
        chk("irq", 32'(oIrq), 32'(eIrq));
        chk("done", 32'(oDone), 32'(eDone));
        chk("recCount", 32'(oRecCount), 32'(recDone));
        chk("missed", 32'(oTrigMissed), 32'(eMissed));
        chk("err", 32'(oErr), 32'(eErr));
        if (oIrq === 1'b1) irqSeen++;
    endtask

    task automatic tick();
        modelStep();
        @(posedge adcCLK);
        #1;
        checkAll();
    endtask

    task automatic idle(input int n);
        iTrigLine = 0; iAdcValid = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic arm(input int len, input int nrec);
        iArm = 1; iRecLength = ADDR_W'(len); iNumRecords = 8'(nrec);
        tick();
        iArm = 0;
    endtask

    task automatic trigPulse();
        iTrigLine = 1; iAdcValid = 0;
        tick();
        iTrigLine = 0;
    endtask

    task automatic stream(input int n, input bit randValid);
        for (int i = 0; i < n; i++) begin
            iAdcValid = randValid ? 1'($urandom_range(0, 1)) : 1'b1;
            iAdcData  = $urandom();
            tick();
        end
        iAdcValid = 0;
    endtask

    task automatic streamToEnd(input string tag, input bit randValid);
        int budget;
        budget = 60;
        while (mSt == ST_CAPTURE && budget > 0) begin
            stream(1, randValid);
            budget--;
        end
        chk(tag, 32'(mSt == ST_CAPTURE), 32'(0));
    endtask

    initial begin
        iRst_n = 0; iTrigLine = 0; iArm = 0; iAbort = 0;
        iRecLength = '0; iNumRecords = '0; iAdcValid = 0; iAdcData = '0;
        idle(2);
        chk("rst_state", 32'(oState), 32'(ST_IDLE));
        chk("rst_wrAddr", 32'(oWrAddr), 32'(0));
        chk("rst_wrData", oWrData, 32'(0));
        iRst_n = 1;
        idle(2);

        // Single record of 4, continuous samples
        arm(4, 1);
        idle(2);
        irqSeen = 0;
        trigPulse();
        chk("t1_capture", 32'(oState), 32'(ST_CAPTURE));
        stream(6, 0);
        chk("t1_done", 32'(oDone), 32'(1));
        chk("t1_irqs", 32'(irqSeen), 32'(1));
        chk("t1_lastAddr", 32'(oWrAddr), 32'(3));

        // Two records of 3, packed
        arm(3, 2);
        irqSeen = 0;
        trigPulse();
        streamToEnd("t2_rec1_timeout", 1);
        idle(10);
        trigPulse();
        streamToEnd("t2_rec2_timeout", 1);
        idle(2);
        chk("t2_recCount", 32'(oRecCount), 32'(2));
        chk("t2_irqs", 32'(irqSeen), 32'(1));
        chk("t2_lastAddr", 32'(oWrAddr), 32'(5));

        // Missed triggers in IDLE and mid-capture
        iAbort = 1; tick(); iAbort = 0;
        trigPulse();
        idle(1);
        chk("t3_missedIdle", 32'(oTrigMissed), 32'(1));
        arm(6, 1);
        trigPulse();
        stream(2, 0);
        iTrigLine = 1; stream(1, 0); iTrigLine = 0;
        streamToEnd("t3_timeout", 0);
        chk("t3_missedCap", 32'(oTrigMissed), 32'(1));
        chk("t3_done", 32'(oDone), 32'(1));

        // Overflow: 15 + 15 samples into a 16-word buffer
        arm(15, 2);
        trigPulse();
        streamToEnd("t4_rec1_timeout", 0);
        trigPulse();
        streamToEnd("t4_rec2_timeout", 0);
        stream(4, 0);
        chk("t4_err", 32'(oErr), 32'(2));
        chk("t4_state", 32'(oState), 32'(ST_ERROR));
        chk("t4_lastAddr", 32'(oWrAddr), 32'(15));

        // Boundary: 8 + 8 ends exactly at the top address without error
        arm(8, 2);
        trigPulse();
        streamToEnd("t5_rec1_timeout", 1);
        trigPulse();
        streamToEnd("t5_rec2_timeout", 1);
        idle(1);
        chk("t5_state", 32'(oState), 32'(ST_DONE));
        chk("t5_err", 32'(oErr), 32'(0));

        // Bad configurations
        arm(0, 3);
        chk("t6_lenErr", 32'(oErr), 32'(1));
        arm(3, 0);
        chk("t6_recErr", 32'(oErr), 32'(1));
        chk("t6_state", 32'(oState), 32'(ST_ERROR));

        // Abort mid-capture, with abort and arm together
        arm(5, 1);
        trigPulse();
        stream(2, 0);
        iAbort = 1; iArm = 1; stream(1, 0); iAbort = 0; iArm = 0;
        chk("t7_state", 32'(oState), 32'(ST_IDLE));
        chk("t7_wrEn", 32'(oWrEn), 32'(0));
        idle(2);

        // Reset mid-capture
        arm(5, 1);
        trigPulse();
        stream(2, 0);
        iRst_n = 0; idle(1);
        chk("t8_state", 32'(oState), 32'(0));
        chk("t8_wrAddr", 32'(oWrAddr), 32'(0));
        chk("t8_wrData", oWrData, 32'(0));
        chk("t8_recCount", 32'(oRecCount), 32'(0));
        iRst_n = 1;
        idle(1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            iArm        = ($urandom_range(0, 15) == 0);
            iAbort      = ($urandom_range(0, 79) == 0);
            iTrigLine   = ($urandom_range(0, 3) == 0);
            iAdcValid   = 1'($urandom_range(0, 1));
            iAdcData    = $urandom();
            iRecLength  = ADDR_W'($urandom_range(0, 6));
            iNumRecords = 8'($urandom_range(0, 3));
            tick();
        end
        iArm = 0; iAbort = 0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
